// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single core memory port between the instruction
//                fetch unit (read-only) and the load/store unit (read/write).
//                One outstanding transaction at a time. Ties are broken in
//                favour of the LSU unless it won the previous grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // instruction fetch requester
    input  logic              i_ifu_req_valid,
    output logic              o_ifu_req_ready,
    input  logic [AW-1:0]     i_ifu_addr,
    output logic              o_ifu_resp_valid,
    output logic [DW-1:0]     o_ifu_rdata,
    // load/store requester
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic [AW-1:0]     i_lsu_addr,
    input  logic              i_lsu_wen,
    input  logic [DW-1:0]     i_lsu_wdata,
    input  logic [DW/8-1:0]   i_lsu_wmask,
    output logic              o_lsu_resp_valid,
    output logic [DW-1:0]     o_lsu_rdata,
    // memory / bus bridge side
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_wen,
    output logic [DW-1:0]     o_mem_wdata,
    output logic [DW/8-1:0]   o_mem_wmask,
    input  logic              i_mem_resp_valid,
    input  logic [DW-1:0]     i_mem_rdata
);

    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // owner / last_grant encoding: 0 = IFU, 1 = LSU
    state_t           state_q,      state_d;
    logic             owner_q,      owner_d;
    logic             last_grant_q, last_grant_d;
    logic [AW-1:0]    addr_q,       addr_d;
    logic             wen_q,        wen_d;
    logic [DW-1:0]    wdata_q,      wdata_d;
    logic [MW-1:0]    wmask_q,      wmask_d;

    logic             w_grant_lsu;
    logic             w_grant_ifu;
    logic             w_resp_hit;

    // Arbitration, handshakes, response routing and next-state selection
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        o_ifu_req_ready  = 1'b0;
        o_lsu_req_ready  = 1'b0;
        o_mem_req_valid  = 1'b0;
        o_ifu_resp_valid = 1'b0;
        o_lsu_resp_valid = 1'b0;
        o_ifu_rdata      = '0;
        o_lsu_rdata      = '0;

        // LSU wins a tie unless it took the previous grant
        w_grant_lsu = i_lsu_req_valid && (!i_ifu_req_valid || !last_grant_q);
        w_grant_ifu = i_ifu_req_valid && !w_grant_lsu;
        // A reset in flight suppresses any response pulse
        w_resp_hit  = i_mem_resp_valid && !i_rst;

        case (state_q)
            S_IDLE: begin
                o_lsu_req_ready = w_grant_lsu && !i_rst;
                o_ifu_req_ready = w_grant_ifu && !i_rst;
                if (w_grant_lsu) begin
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    addr_d       = i_lsu_addr;
                    wen_d        = i_lsu_wen;
                    wdata_d      = i_lsu_wdata;
                    wmask_d      = i_lsu_wmask;
                    state_d      = S_REQ;
                end else if (w_grant_ifu) begin
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    addr_d       = i_ifu_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp_hit) begin
                    if (owner_q) begin
                        o_lsu_resp_valid = 1'b1;
                        o_lsu_rdata      = i_mem_rdata;
                    end else begin
                        o_ifu_resp_valid = 1'b1;
                        o_ifu_rdata      = i_mem_rdata;
                    end
                end
                if (i_mem_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory request fields come straight from the latched request so they
    // hold steady for as long as the bridge stalls
    assign o_mem_addr  = addr_q;
    assign o_mem_wen   = wen_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wmask = wmask_q;

    // State and latched-request registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed, table-driven bench for mem_port_arbiter with a
//                memory responder emulated inline and hand-written sequences
//                for reset-abort and stray-response cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [AW-1:0]   ifu_addr;
    logic [DW-1:0]   ifu_rdata;
    logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_wdata, lsu_rdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [DW/8-1:0] mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ifu_req_valid  (ifu_req_valid),
        .o_ifu_req_ready  (ifu_req_ready),
        .i_ifu_addr       (ifu_addr),
        .o_ifu_resp_valid (ifu_resp_valid),
        .o_ifu_rdata      (ifu_rdata),
        .i_lsu_req_valid  (lsu_req_valid),
        .o_lsu_req_ready  (lsu_req_ready),
        .i_lsu_addr       (lsu_addr),
        .i_lsu_wen        (lsu_wen),
        .i_lsu_wdata      (lsu_wdata),
        .i_lsu_wmask      (lsu_wmask),
        .o_lsu_resp_valid (lsu_resp_valid),
        .o_lsu_rdata      (lsu_rdata),
        .o_mem_req_valid  (mem_req_valid),
        .i_mem_req_ready  (mem_req_ready),
        .o_mem_addr       (mem_addr),
        .o_mem_wen        (mem_wen),
        .o_mem_wdata      (mem_wdata),
        .o_mem_wmask      (mem_wmask),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_rdata      (mem_rdata)
    );

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic        lsu_wen;
        logic [63:0] ifu_addr;
        logic [63:0] lsu_addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        int          stall;    // cycles with mem ready low before acceptance
        int          wait_c;   // idle cycles in WAIT before the response
        logic        exp_lsu;  // hand-computed winner: 1 = LSU, 0 = IFU
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ifu_ready"}, ifu_req_ready, 0);
        chk({tag, " lsu_ready"}, lsu_req_ready, 0);
        chk({tag, " mem_valid"}, mem_req_valid, 0);
        chk({tag, " ifu_resp"},  ifu_resp_valid, 0);
        chk({tag, " lsu_resp"},  lsu_resp_valid, 0);
        chk({tag, " ifu_rdata"}, ifu_rdata, 0);
        chk({tag, " lsu_rdata"}, lsu_rdata, 0);
    endtask

    // One full transaction starting in IDLE: grant, REQ (with stalls), WAIT, response
    task automatic run_vec(input vec_t v);
        logic [63:0] e_addr, e_wdata;
        logic [7:0]  e_wmask;
        logic        e_wen;
        ifu_req_valid  = v.ifu_v;
        ifu_addr       = v.ifu_addr;
        lsu_req_valid  = v.lsu_v;
        lsu_addr       = v.lsu_addr;
        lsu_wen        = v.lsu_wen;
        lsu_wdata      = v.wdata;
        lsu_wmask      = v.wmask;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("grant ifu_ready", ifu_req_ready, v.ifu_v && !v.exp_lsu);
        chk("grant lsu_ready", lsu_req_ready, v.exp_lsu);
        chk("idle mem_valid", mem_req_valid, 0);
        e_addr  = v.exp_lsu ? v.lsu_addr : v.ifu_addr;
        e_wen   = v.exp_lsu ? v.lsu_wen  : 1'b0;
        e_wdata = v.exp_lsu ? v.wdata    : 64'd0;
        e_wmask = v.exp_lsu ? v.wmask    : 8'd0;
        tick;
        // Requester fields change after the handshake; the latched copy must hold
        ifu_addr  = ~v.ifu_addr;
        lsu_addr  = ~v.lsu_addr;
        lsu_wdata = ~v.wdata;
        lsu_wmask = ~v.wmask;
        lsu_wen   = !v.lsu_wen;
        for (int c = 0; c <= v.stall; c++) begin
            mem_req_ready = (c == v.stall);
            #1;
            chk("req mem_valid", mem_req_valid, 1);
            chk("req mem_addr",  mem_addr, e_addr);
            chk("req mem_wen",   mem_wen, e_wen);
            chk("req mem_wdata", mem_wdata, e_wdata);
            chk("req mem_wmask", mem_wmask, e_wmask);
            chk("req ifu_ready", ifu_req_ready, 0);
            chk("req lsu_ready", lsu_req_ready, 0);
            tick;
        end
        mem_req_ready = 1'b0;
        for (int c = 0; c < v.wait_c; c++) begin
            mem_rdata = {$urandom, $urandom};
            #1;
            chk("wait mem_valid", mem_req_valid, 0);
            chk("wait ifu_resp",  ifu_resp_valid, 0);
            chk("wait lsu_resp",  lsu_resp_valid, 0);
            chk("wait ifu_rdata", ifu_rdata, 0);
            chk("wait lsu_rdata", lsu_rdata, 0);
            tick;
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = v.rdata;
        #1;
        chk("resp ifu_valid", ifu_resp_valid, !v.exp_lsu);
        chk("resp lsu_valid", lsu_resp_valid, v.exp_lsu);
        if (!v.exp_lsu) begin
            chk("resp ifu_rdata", ifu_rdata, v.rdata);
            chk("resp lsu_rdata idle", lsu_rdata, 0);
        end else begin
            chk("resp ifu_rdata idle", ifu_rdata, 0);
            if (!v.lsu_wen) chk("resp lsu_rdata", lsu_rdata, v.rdata);
        end
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("pulse ifu_resp", ifu_resp_valid, 0);
        chk("pulse lsu_resp", lsu_resp_valid, 0);
    endtask

    initial begin
        //        ifu lsu wen ifu_addr                lsu_addr                wdata                   wmask  rdata                   st wt exp
        vecs[0] = '{1, 0, 0, 64'h0000_0000_8000_0000, 64'h0,                  64'h0,                  8'h00, 64'h0000_0013_0000_0093, 0, 0, 0};
        vecs[1] = '{0, 1, 1, 64'h0000_0000_1111_0000, 64'h0000_0000_8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'h0,                  3, 0, 1};
        vecs[2] = '{1, 0, 0, 64'h0000_0000_8000_0008, 64'h0000_0000_2222_0000, 64'h0,                  8'h00, 64'h0000_0000_0000_1111, 1, 1, 0};
        vecs[3] = '{1, 1, 0, 64'h0000_0000_8000_0010, 64'h0000_0000_8000_3000, 64'h0,                  8'h00, 64'h0000_0000_0000_AAAA, 0, 0, 1};
        vecs[4] = '{1, 1, 1, 64'h0000_0000_8000_0018, 64'h0000_0000_8000_3008, 64'h5555_5555_5555_5555, 8'hF0, 64'h0000_0000_0000_BBBB, 0, 0, 0};
        vecs[5] = '{1, 1, 1, 64'h0000_0000_8000_0020, 64'h0000_0000_8000_3010, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,                  2, 1, 1};
        vecs[6] = '{1, 1, 0, 64'h0000_0000_8000_0028, 64'h0000_0000_8000_3018, 64'h0,                  8'h00, 64'h0000_0000_0000_CCCC, 0, 2, 0};
        vecs[7] = '{0, 1, 0, 64'h0000_0000_3333_0000, 64'h0000_0000_8000_2000, 64'h0,                  8'h00, 64'h0000_0000_0000_1234, 0, 5, 1};
        vecs[8] = '{1, 0, 0, 64'h0000_0000_8000_0200, 64'h0,                  64'h0,                  8'h00, 64'h0000_0000_0000_0777, 0, 0, 0};

        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset mem_addr",  mem_addr, 0);
        chk("reset mem_wen",   mem_wen, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset mem_wmask", mem_wmask, 0);

        // IFU alone, stalled store, alternating contention, long-wait load
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while in WAIT, stale response afterwards
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        #1;
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0000_8000_0100;
        #1;
        chk("abort grant", ifu_req_ready, 1);
        tick;
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("abort req valid", mem_req_valid, 1);
        tick;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort rst ifu_resp", ifu_resp_valid, 0);
        tick;
        rst = 1'b0;
        #1;
        chk_quiet("post-abort");
        chk("post-abort mem_addr", mem_addr, 0);
        tick;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hFACE_FACE_FACE_FACE;
        #1;
        chk_quiet("stale resp");
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk("stale no req", mem_req_valid, 0);
        run_vec(vecs[8]);

        // Stray response while IDLE with no requests
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0BAD_0BAD_0BAD_0BAD;
        #1;
        chk_quiet("spurious");
        tick;
        mem_resp_valid = 1'b0;
        #1;
        chk_quiet("spurious after");
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
